// File: rtl/decoder.sv
// 4x4 keypad scanner: walks one active-low column at a time, samples the synchronized
// rows once per column, and debounces a single key across two consecutive full sweeps.
module decoder #(
  parameter int unsigned SCAN_TICKS = 100000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] dec_out,
  output logic [3:0] button_pressed
);

  localparam int unsigned CNT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_TICKS - 1);

  logic [3:0]       row_meta_q, row_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic [3:0]       cand_q, cand_d;
  logic             cand_vld_q, cand_vld_d;
  logic [3:0]       dec_q, dec_d;
  logic             held_q, held_d;
  logic             pulse_q, pulse_d;
  logic             multi_q, multi_d;

  logic             sample_s, sweep_end_s;
  logic [1:0]       col_idx_s;
  logic [2:0]       hits_s, sum_s;
  logic [3:0]       code_s;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b11_11: k = 4'h1;  4'b11_10: k = 4'h2;  4'b11_01: k = 4'h3;  4'b11_00: k = 4'hA;
      4'b10_11: k = 4'h4;  4'b10_10: k = 4'h5;  4'b10_01: k = 4'h6;  4'b10_00: k = 4'hB;
      4'b01_11: k = 4'h7;  4'b01_10: k = 4'h8;  4'b01_01: k = 4'h9;  4'b01_00: k = 4'hC;
      4'b00_11: k = 4'h0;  4'b00_10: k = 4'hF;  4'b00_01: k = 4'hE;  4'b00_00: k = 4'hD;
      default:  k = 4'h0;
    endcase
    return k;
  endfunction

  assign sample_s    = (cnt_q == CNT_MAX);
  assign sweep_end_s = sample_s && (col_q == 4'b1110);

  // Column index of the driven column, and row hits / last code for the current sample
  always_comb begin
    case (col_q)
      4'b0111: col_idx_s = 2'd3;
      4'b1011: col_idx_s = 2'd2;
      4'b1101: col_idx_s = 2'd1;
      4'b1110: col_idx_s = 2'd0;
      default: col_idx_s = 2'd0;
    endcase
    hits_s = 3'd0;
    code_s = acc_code_q;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        hits_s = hits_s + 3'd1;
        code_s = key_code(2'(r), col_idx_s);
      end else begin
        hits_s = hits_s;
      end
    end
    sum_s = {1'b0, acc_cnt_q} + hits_s;
  end

  // Scan timing, sweep accumulation and sweep-end debounce decision
  always_comb begin
    cnt_d      = sample_s ? '0 : cnt_q + CNT_W'(1);
    col_d      = sample_s ? {col_q[0], col_q[3:1]} : col_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    dec_d      = dec_q;
    held_d     = held_q;
    multi_d    = multi_q;
    pulse_d    = 1'b0;
    if (sweep_end_s) begin
      acc_cnt_d  = 2'd0;
      acc_code_d = 4'h0;
      if (sum_s == 3'd0) begin
        held_d     = 1'b0;
        multi_d    = 1'b0;
        cand_vld_d = 1'b0;
      end else if (sum_s >= 3'd2) begin
        held_d     = 1'b1;
        multi_d    = 1'b1;
        cand_vld_d = 1'b0;
      end else begin
        multi_d = 1'b0;
        if (cand_vld_q && (code_s == cand_q)) begin
          held_d = 1'b1;
          // A continuously held key keeps held_q set, so it never re-pulses
          if (!held_q || (code_s != dec_q)) begin
            dec_d   = code_s;
            pulse_d = 1'b1;
          end else begin
            dec_d   = dec_q;
          end
        end else begin
          cand_d     = code_s;
          cand_vld_d = 1'b1;
        end
      end
    end else if (sample_s) begin
      acc_cnt_d  = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
      acc_code_d = code_s;
    end else begin
      acc_cnt_d  = acc_cnt_q;
    end
  end

  // State registers, including the 2-flop row synchronizer
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      cnt_q      <= '0;
      col_q      <= 4'b0111;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'h0;
      cand_q     <= 4'h0;
      cand_vld_q <= 1'b0;
      dec_q      <= 4'h0;
      held_q     <= 1'b0;
      pulse_q    <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      dec_q      <= dec_d;
      held_q     <= held_d;
      pulse_q    <= pulse_d;
      multi_q    <= multi_d;
    end
  end

  assign col            = col_q;
  assign dec_out        = dec_q;
  assign button_pressed = {1'b0, multi_q, pulse_q, held_q};

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for the keypad decoder: a keypad model drives rows from col, stimulus
// queues expected new-key pulses, and a monitor checks every pulse and the column walk.
module tb_decoder;

  localparam int unsigned TICKS = 8;
  localparam int unsigned SWEEP = 4 * TICKS;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic [3:0] row, col, dec_out, button_pressed;
  logic [15:0] keys;

  typedef struct {
    logic [3:0] dec;
    logic [3:0] status;
    int         deadline;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [3:0] m_col;
  int         m_cnt;
  logic [3:0] prev_dec = 4'h0;

  decoder #(.SCAN_TICKS(TICKS)) dut (
    .clk_100MHz    (clk_100MHz),
    .reset         (reset),
    .row           (row),
    .col           (col),
    .dec_out       (dec_out),
    .button_pressed(button_pressed)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  // keys index = row*4 + col-index; a pressed key pulls its row low while its column is low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Reference column walk: one column per TICKS cycles, 0111 -> 1011 -> 1101 -> 1110
  always @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
      m_col <= 4'b0111;
    end else if (m_cnt == TICKS - 1) begin
      m_cnt <= 0;
      m_col <= {m_col[0], m_col[3:1]};
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per new-key pulse and checks the column walk every cycle
  always @(negedge clk_100MHz) begin
    exp_t e;
    if (!reset) begin
      check("col_walk", {28'd0, col}, {28'd0, m_col});
      if (button_pressed[1]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {28'd0, dec_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pulse_dec", {28'd0, dec_out}, {28'd0, e.dec});
          check("pulse_status", {28'd0, button_pressed}, {28'd0, e.status});
          check("pulse_latency", {31'd0, (cyc <= e.deadline)}, 32'd1);
        end
      end else if (dec_out !== prev_dec) begin
        check("dec_change_without_pulse", {28'd0, dec_out}, {28'd0, prev_dec});
      end
    end
    prev_dec = dec_out;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic expect_pulse(input logic [3:0] dec, input int budget);
    exp_t e;
    e.dec      = dec;
    e.status   = 4'b0011;
    e.deadline = cyc + budget;
    exp_q.push_back(e);
  endtask

  task automatic check_state(input string tag, input logic [3:0] dec, input logic held,
                             input logic multi);
    check({tag, "_dec"}, {28'd0, dec_out}, {28'd0, dec});
    check({tag, "_held"}, {31'd0, button_pressed[0]}, {31'd0, held});
    check({tag, "_multi"}, {31'd0, button_pressed[2]}, {31'd0, multi});
    check({tag, "_bit3"}, {31'd0, button_pressed[3]}, 32'd0);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    keys  = 16'h0000;
    wait_cycles(3);
    check("reset_dec", {28'd0, dec_out}, 32'd0);
    check("reset_status", {28'd0, button_pressed}, 32'd0);
    check("reset_col", {28'd0, col}, 32'h7);
    reset = 1'b0;

    // Idle keypad
    wait_cycles(10 * SWEEP);
    check_state("idle", 4'h0, 1'b0, 1'b0);
    check("idle_status", {28'd0, button_pressed}, 32'd0);

    // Key 5: row 2, column index 2
    keys[10] = 1'b1;
    expect_pulse(4'h5, 3 * SWEEP + 2);
    wait_cycles(4 * SWEEP);
    check_state("key5", 4'h5, 1'b1, 1'b0);

    // Switch to D: row 0, column index 0
    keys[10] = 1'b0;
    keys[0]  = 1'b1;
    expect_pulse(4'hD, 2 * SWEEP + 2);
    wait_cycles(3 * SWEEP);
    check_state("keyD", 4'hD, 1'b1, 1'b0);

    keys = 16'h0000;
    wait_cycles(2 * SWEEP);
    check_state("releaseD", 4'hD, 1'b0, 1'b0);

    // Keys 1 and A together: row 3, columns 3 and 0
    keys[15] = 1'b1;
    keys[12] = 1'b1;
    wait_cycles(3 * SWEEP);
    check_state("multi", 4'hD, 1'b1, 1'b1);
    keys = 16'h0000;
    wait_cycles(2 * SWEEP);
    check_state("release_multi", 4'hD, 1'b0, 1'b0);

    // One-sweep glitch on 8: row 1, column index 2
    keys[6] = 1'b1;
    wait_cycles(SWEEP);
    keys = 16'h0000;
    wait_cycles(3 * SWEEP);
    check_state("glitch8", 4'hD, 1'b0, 1'b0);

    // Key 3 (row 3, column index 1), then reset in the middle of a sweep
    keys[13] = 1'b1;
    expect_pulse(4'h3, 3 * SWEEP + 2);
    wait_cycles(3 * SWEEP);
    check_state("key3", 4'h3, 1'b1, 1'b0);
    wait_cycles(10);
    reset = 1'b1;
    #1;
    check("midreset_dec", {28'd0, dec_out}, 32'd0);
    check("midreset_status", {28'd0, button_pressed}, 32'd0);
    check("midreset_col", {28'd0, col}, 32'h7);
    wait_cycles(3);
    reset = 1'b0;
    expect_pulse(4'h3, 3 * SWEEP + 2);
    wait_cycles(4 * SWEEP);
    check_state("key3_after_reset", 4'h3, 1'b1, 1'b0);

    keys = 16'h0000;
    wait_cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter SCAN_TICKS, default 100000, SHALL set the clk_100MHz cycles each column stays driven (1 ms at 100 MHz); legal minimum 8.
REQ-002 clk_100MHz  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 row  input  4  SHALL carry the keypad row lines, active-low with external pull-ups; row[3] is the top row.
REQ-005 col  output  4  SHALL drive the keypad columns, active-low, exactly one low at any time; col[3] is the leftmost column.
REQ-006 dec_out  output  4  SHALL hold the hex code of the last debounced key.
REQ-007 button_pressed  output  4  SHALL report status: bit0 key held, bit1 new-key pulse, bit2 multiple keys, bit3 constant 0.

Function
REQ-008 Key map (row-low, col-low -> code): row[3]: col[3..0] = 1,2,3,A; row[2]: 4,5,6,B; row[1]: 7,8,9,C; row[0]: 0,F,E,D.
REQ-009 row SHALL pass through a 2-flop synchronizer before any use.
REQ-010 A tick counter SHALL count 0..SCAN_TICKS-1 and wrap; the column SHALL advance on the wrap in the order 0111 -> 1011 -> 1101 -> 1110 -> 0111.
REQ-011 Synchronized rows SHALL be sampled in the cycle where counter = SCAN_TICKS-1, before the column advances.
REQ-012 One sweep SHALL cover the four column samples, ending at the sample taken with col = 1110.
REQ-013 Within a sweep, the block SHALL count low rows across all samples and record the code of the last low row found.
REQ-014 At sweep end, with 0 keys: bit0 and bit2 SHALL clear, dec_out SHALL hold, and the debounce candidate SHALL clear.
REQ-015 At sweep end, with more than one key: bit2 and bit0 SHALL set, dec_out SHALL hold, and the candidate SHALL clear.
REQ-016 At sweep end, with exactly one key: bit2 SHALL clear.
  - If the code equals the candidate from the previous sweep, the key is debounced.
  - Otherwise the code SHALL become the new candidate and no output SHALL change.
REQ-017 On a debounced key:
  - bit0 SHALL set.
  - If bit0 was 0 or the code differs from dec_out, dec_out SHALL load the code in the same cycle and bit1 SHALL pulse high for exactly one cycle.
  - A key held continuously SHALL NOT re-pulse bit1.
REQ-018 Latency from a stable single press to the dec_out update SHALL be at most 3 sweeps plus 2 cycles; status bits SHALL update only at sweep ends.
REQ-019 Rows changing during a sweep SHALL only affect that sweep's evaluation; no partial-sweep updates.
REQ-020 All outputs SHALL be registered; no combinational path from row to any output.

Reset
REQ-021 While reset is high: col = 0111, counter = 0, dec_out = 0, button_pressed = 0, candidate and sweep accumulators cleared, synchronizers = 1111.
REQ-022 Reset asserted mid-sweep SHALL discard the partial sweep; scanning SHALL restart from col = 0111 at counter 0 on the first edge after release.

Verification (SCAN_TICKS = 8)
REQ-023 Reset, rows = 1111 for 10 sweeps -> col cycles 0111/1011/1101/1110 every 8 cycles; dec_out = 0, button_pressed = 0 throughout.
REQ-024 Model key "5" (row[2] low while col = 1011), held 4 sweeps -> dec_out = 5, bit0 = 1, exactly one bit1 pulse, within 3 sweeps + 2 cycles.
REQ-025 Hold "5", switch to "D" (row[0] low while col = 1110) -> dec_out = D after 2 sweeps, second bit1 pulse; release -> bit0 = 0, dec_out stays D.
REQ-026 Key "1" and key "A" low in the same sweep -> bit2 = 1, bit0 = 1, dec_out unchanged, no bit1 pulse.
REQ-027 Single-sweep glitch on key "8" -> no dec_out change, no bit1 pulse.
REQ-028 Assert reset mid-sweep while "3" is held -> outputs return to reset values immediately; after release "3" is decoded again with a fresh bit1 pulse.
